// File: rtl/seq_bcd_converter_if.sv
// seq_bcd_converter_if
//   Bus bundle between a producer of 8-bit binary values and the sequential
//   binary-to-BCD converter.
//   master : drives bin/start, observes status and BCD digits.
//   slave  : the converter; samples bin/start, drives busy, done, digits and
//            the leading-zero blank flags.
//   Signals:
//     bin            [7:0]  unsigned value to convert
//     start                 conversion request (sampled only while idle)
//     busy                  conversion in progress
//     done                  one-cycle pulse when new digits are valid
//     ONES           [3:0]  BCD units digit
//     TENS           [3:0]  BCD tens digit
//     HUNDREDS       [1:0]  BCD hundreds digit (0-2)
//     blank_tens            tens display may be blanked (leading zero)
//     blank_hundreds        hundreds display may be blanked (leading zero)
interface seq_bcd_converter_if;
   logic [7:0] bin;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] ONES;
   logic [3:0] TENS;
   logic [1:0] HUNDREDS;
   logic       blank_tens;
   logic       blank_hundreds;

   modport master (
      output bin, start,
      input  busy, done, ONES, TENS, HUNDREDS, blank_tens, blank_hundreds
   );

   modport slave (
      input  bin, start,
      output busy, done, ONES, TENS, HUNDREDS, blank_tens, blank_hundreds
   );
endinterface

// File: rtl/seq_bcd_converter.sv
// seq_bcd_converter
//   Converts an 8-bit unsigned value into three BCD digits with the
//   shift-and-add-3 (double dabble) algorithm, one bit per clock.
//   A conversion takes 8 SHIFT cycles plus one DONE cycle; digits and blank
//   flags are registered and only change on the done pulse.
//   Parameter:
//     AUTO      1: a change of bin versus the last converted value starts a
//               conversion on its own; 0: only start triggers.
//   Ports:
//     CLOCK_50  system clock, rising edge
//     reset     synchronous, active-high reset
//     bus       seq_bcd_converter_if slave modport (bin/start in, status and
//               digits out)
module seq_bcd_converter #(
   parameter bit AUTO = 1'b1
) (
   input logic                CLOCK_50,
   input logic                reset,
   seq_bcd_converter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] shift_reg;
   logic [7:0] last_bin;
   logic [9:0] scratch;      // {hundreds[1:0], tens[3:0], ones[3:0]}
   logic [2:0] count;
   logic [3:0] ones_adj;
   logic [3:0] tens_adj;
   logic       trigger;

   // Add-3 correction of the ones and tens nibbles, applied before each shift.
   // Hundreds never exceeds 2, so it needs no correction.
   always_comb begin
      ones_adj = scratch[3:0];
      tens_adj = scratch[7:4];
      if (scratch[3:0] >= 4'd5) begin
         ones_adj = scratch[3:0] + 4'd3;
      end else begin
         ones_adj = scratch[3:0];
      end
      if (scratch[7:4] >= 4'd5) begin
         tens_adj = scratch[7:4] + 4'd3;
      end else begin
         tens_adj = scratch[7:4];
      end
   end

   // Conversion request: explicit start, or (AUTO) a new value on bin.
   always_comb begin
      trigger = 1'b0;
      if (bus.start) begin
         trigger = 1'b1;
      end else if ((AUTO == 1'b1) && (bus.bin != last_bin)) begin
         trigger = 1'b1;
      end else begin
         trigger = 1'b0;
      end
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state              <= IDLE;
         shift_reg          <= 8'd0;
         last_bin           <= 8'd0;
         scratch            <= 10'd0;
         count              <= 3'd0;
         bus.busy           <= 1'b0;
         bus.done           <= 1'b0;
         bus.ONES           <= 4'd0;
         bus.TENS           <= 4'd0;
         bus.HUNDREDS       <= 2'd0;
         bus.blank_tens     <= 1'b1;
         bus.blank_hundreds <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (trigger) begin
                  shift_reg <= bus.bin;
                  last_bin  <= bus.bin;
                  scratch   <= 10'd0;
                  count     <= 3'd0;
                  state     <= SHIFT;
                  bus.busy  <= 1'b1;
               end else begin
                  bus.busy  <= 1'b0;
               end
            end
            SHIFT: begin
               // Corrected scratch and operand shift left together as one
               // 18-bit register; hundreds bit 9 falls off (never set before
               // the last shift for inputs up to 255).
               {scratch, shift_reg} <= {scratch[8], tens_adj, ones_adj, shift_reg, 1'b0};
               count    <= count + 3'd1;
               bus.done <= 1'b0;
               bus.busy <= 1'b1;
               if (count == 3'd7) begin
                  state <= DONE;
               end else begin
                  state <= SHIFT;
               end
            end
            DONE: begin
               bus.ONES           <= scratch[3:0];
               bus.TENS           <= scratch[7:4];
               bus.HUNDREDS       <= scratch[9:8];
               bus.blank_hundreds <= (scratch[9:8] == 2'd0);
               bus.blank_tens     <= (scratch[9:8] == 2'd0) && (scratch[7:4] == 4'd0);
               bus.done           <= 1'b1;
               bus.busy           <= 1'b0;
               state              <= IDLE;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule
